mouse_hit_detector: RTL
=======================

Name: mouse_hit_detector

Overview:
- Parametrised successor to the single-ball click test. Checks the mouse position against NUM_TARGETS square targets, each with its own valid flag.
- Left and middle buttons are edge-detected, so one press produces exactly one event.
- Outputs are registered: per-target respawn pulses, hit/miss/skip pulses, and saturating hit and miss counters.
- Sits between the PS/2 mouse decoder and the ball spawner/score display in the reflex-trainer game.

Parameters:
- NUM_TARGETS, 4, number of simultaneous targets (1..16)
- COORD_W, 10, width of every X/Y coordinate
- TARGET_SIZE, 40, side length in pixels of each square target
- CNT_W, 16, width of the hit and miss counters

Ports:
- CLK  input  1  system clock
- RESET  input  1  synchronous, active-high reset
- ENABLE  input  1  1 = clicks are scored; 0 = clicks are ignored (edge tracking continues)
- BALL_X  input  NUM_TARGETS*COORD_W  packed target top-left X; target i is in bits [i*COORD_W +: COORD_W]
- BALL_Y  input  NUM_TARGETS*COORD_W  packed target top-left Y, same packing as BALL_X
- TARGET_VALID  input  NUM_TARGETS  1 = target i is on screen and can be hit
- MOUSE_X_POS  input  COORD_W  cursor X
- MOUSE_Y_POS  input  COORD_W  cursor Y
- MOUSE_LEFT  input  1  left button level
- MOUSE_MIDDLE  input  1  middle button level (skip/respawn)
- NEW_BALL  output  NUM_TARGETS  one-cycle pulse per target to respawn
- HIT  output  1  one-cycle pulse on a scored hit
- HIT_IDX  output  clog2(NUM_TARGETS), min 1  index of the last target hit; holds between hits
- MISS  output  1  one-cycle pulse on a left click that hit nothing
- SKIP  output  1  one-cycle pulse on a middle click
- HIT_COUNT  output  CNT_W  saturating count of hits
- MISS_COUNT  output  CNT_W  saturating count of misses

Behaviour:
- Reset: all outputs are 0. Button history registers load 0. FSM goes to IDLE.
  - Consequence: a button already held when RESET deasserts produces an edge on the first cycle after reset.
- Edge detection:
  - left_rise = MOUSE_LEFT & ~left_q; mid_rise = MOUSE_MIDDLE & ~mid_q.
  - left_q and mid_q are registered copies of the buttons, updated every cycle including while ENABLE=0.
- Hit test for target i:
  - in_i = TARGET_VALID[i] & (MX >= BX_i) & (MX < BX_i+TARGET_SIZE) & (MY >= BY_i) & (MY < BY_i+TARGET_SIZE).
  - Sums are computed at COORD_W+1 bits, so a target near the coordinate maximum never wraps to a small value.
- Priority: when several in_i are 1, the lowest index wins.
- FSM states:
  - IDLE: no button held. Move to HELD on any rise.
  - HELD: at least one button held. Return to IDLE when MOUSE_LEFT=0 and MOUSE_MIDDLE=0.
  - Edges are evaluated in both states. Level-held buttons never retrigger.
- Events, evaluated in edge cycle T and registered; outputs are visible in cycle T+1 for exactly one cycle:
  - If ENABLE=0: no event.
  - Else if mid_rise: SKIP=1, and NEW_BALL = TARGET_VALID sampled in cycle T. Counters are unchanged.
    - Middle click takes priority over a simultaneous left rise. That left press is consumed: no hit, no miss.
  - Else if left_rise and some in_i: HIT=1, NEW_BALL = one-hot of the winning index, HIT_IDX = winning index, HIT_COUNT increments.
  - Else if left_rise: MISS=1, MISS_COUNT increments, NEW_BALL=0.
- Counters saturate at 2^CNT_W-1 and do not wrap. The HIT/MISS pulse is still produced at saturation.
- RESET asserted mid-press: all outputs clear the next cycle and any in-flight pulse is dropped. A button still held after release of RESET counts as a new edge.
- Any move of TARGET_VALID or the coordinates takes effect in the hit test in the same cycle; there is no input registering.

Test Plan:
- Single hit. Targets 0..3 valid at X=100,200,300,400 and Y=50. Mouse (215,60). Left 0→1 held 5 cycles → one-cycle HIT, HIT_IDX=1, NEW_BALL=0010, HIT_COUNT=1; no further pulses while held.
- Box edges. Target 0 at (100,50). Left clicks at X=139,Y=89 → hit; at X=140 → MISS, MISS_COUNT=1; at X=99 → MISS.
- Overlap priority. Targets 1 and 3 both at (300,300), cursor (310,310). Click → HIT_IDX=1 and NEW_BALL=0010; click again with TARGET_VALID[1]=0 → HIT_IDX=3.
- Middle skip and simultaneous press. Middle and left rise in the same cycle over target 2 with TARGET_VALID=1011 → SKIP=1, NEW_BALL=1011, HIT=0, MISS=0, counters unchanged.
- Edge cases:
  - ENABLE=0 click → no pulses.
  - Target at X=1000 with COORD_W=10, cursor X=1020 → hit (no wrap).
  - CNT_W=2: 5 misses → MISS_COUNT=3, MISS pulses on all 5.
- Reset mid-press. Assert RESET during HELD with left held → outputs 0. Deassert RESET with left still held → one event on the first edge cycle after reset.

Source files
------------

// File: rtl/mouse_hit_detector.sv
`default_nettype none
// ============================================================================
// Module   : mouse_hit_detector
// Brief    : Scores edge-detected mouse clicks against NUM_TARGETS square
//            targets; registered hit/miss/skip pulses and saturating counters.
// Revision : 1.0 - initial release
// ============================================================================
module mouse_hit_detector #(
   parameter int NUM_TARGETS = 4,
   parameter int COORD_W     = 10,
   parameter int TARGET_SIZE = 40,
   parameter int CNT_W       = 16
) (
   input  logic                                               CLK,
   input  logic                                               RESET,
   input  logic                                               ENABLE,
   input  logic [NUM_TARGETS*COORD_W-1:0]                     BALL_X,
   input  logic [NUM_TARGETS*COORD_W-1:0]                     BALL_Y,
   input  logic [NUM_TARGETS-1:0]                             TARGET_VALID,
   input  logic [COORD_W-1:0]                                 MOUSE_X_POS,
   input  logic [COORD_W-1:0]                                 MOUSE_Y_POS,
   input  logic                                               MOUSE_LEFT,
   input  logic                                               MOUSE_MIDDLE,
   output logic [NUM_TARGETS-1:0]                             NEW_BALL,
   output logic                                               HIT,
   output logic [((NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1)-1:0] HIT_IDX,
   output logic                                               MISS,
   output logic                                               SKIP,
   output logic [CNT_W-1:0]                                   HIT_COUNT,
   output logic [CNT_W-1:0]                                   MISS_COUNT
);

   localparam int              c_idx_w = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
   localparam logic [COORD_W:0] c_size = (COORD_W+1)'(TARGET_SIZE);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HELD = 1'b1
   } state_t;

   state_t                 r_state;
   logic                   r_left_q;
   logic                   r_mid_q;
   logic [NUM_TARGETS-1:0] r_new_ball;
   logic                   r_hit;
   logic [c_idx_w-1:0]     r_hit_idx;
   logic                   r_miss;
   logic                   r_skip;
   logic [CNT_W-1:0]       r_hit_count;
   logic [CNT_W-1:0]       r_miss_count;

   logic                   w_left_rise;
   logic                   w_mid_rise;
   logic [NUM_TARGETS-1:0] w_in_box;
   logic                   w_any;
   logic [c_idx_w-1:0]     w_win_idx;
   logic [NUM_TARGETS-1:0] w_win_onehot;

   assign w_left_rise = MOUSE_LEFT & ~r_left_q;
   assign w_mid_rise  = MOUSE_MIDDLE & ~r_mid_q;

   // Box end is one bit wider than the coordinate so targets near the
   // screen limit do not wrap around to small values.
   generate
      for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_target
         logic [COORD_W-1:0] w_bx;
         logic [COORD_W-1:0] w_by;
         logic [COORD_W:0]   w_bx_end;
         logic [COORD_W:0]   w_by_end;

         assign w_bx     = BALL_X[gi*COORD_W +: COORD_W];
         assign w_by     = BALL_Y[gi*COORD_W +: COORD_W];
         assign w_bx_end = {1'b0, w_bx} + c_size;
         assign w_by_end = {1'b0, w_by} + c_size;

         assign w_in_box[gi] = TARGET_VALID[gi]
                             & (MOUSE_X_POS >= w_bx) & ({1'b0, MOUSE_X_POS} < w_bx_end)
                             & (MOUSE_Y_POS >= w_by) & ({1'b0, MOUSE_Y_POS} < w_by_end);
      end
   endgenerate

   // Scan from the top down so the lowest matching index is the last write.
   always_comb begin
      w_any     = 1'b0;
      w_win_idx = '0;
      for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
         if (w_in_box[i]) begin
            w_any     = 1'b1;
            w_win_idx = c_idx_w'(i);
         end
      end
   end

   assign w_win_onehot = NUM_TARGETS'(1) << w_win_idx;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state      <= ST_IDLE;
         r_left_q     <= 1'b0;
         r_mid_q      <= 1'b0;
         r_new_ball   <= '0;
         r_hit        <= 1'b0;
         r_hit_idx    <= '0;
         r_miss       <= 1'b0;
         r_skip       <= 1'b0;
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         r_left_q   <= MOUSE_LEFT;
         r_mid_q    <= MOUSE_MIDDLE;
         r_new_ball <= '0;
         r_hit      <= 1'b0;
         r_miss     <= 1'b0;
         r_skip     <= 1'b0;

         case (r_state)
            ST_IDLE: if (w_left_rise || w_mid_rise) r_state <= ST_HELD;
            ST_HELD: if (!MOUSE_LEFT && !MOUSE_MIDDLE) r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase

         // A middle rise swallows any simultaneous left rise.
         if (ENABLE) begin
            if (w_mid_rise) begin
               r_skip     <= 1'b1;
               r_new_ball <= TARGET_VALID;
            end else if (w_left_rise && w_any) begin
               r_hit      <= 1'b1;
               r_hit_idx  <= w_win_idx;
               r_new_ball <= w_win_onehot;
               if (r_hit_count != {CNT_W{1'b1}}) r_hit_count <= r_hit_count + CNT_W'(1);
            end else if (w_left_rise) begin
               r_miss <= 1'b1;
               if (r_miss_count != {CNT_W{1'b1}}) r_miss_count <= r_miss_count + CNT_W'(1);
            end
         end
      end
   end

   assign NEW_BALL   = r_new_ball;
   assign HIT        = r_hit;
   assign HIT_IDX    = r_hit_idx;
   assign MISS       = r_miss;
   assign SKIP       = r_skip;
   assign HIT_COUNT  = r_hit_count;
   assign MISS_COUNT = r_miss_count;

endmodule
`default_nettype wire
